mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, SHALL set the max cycles a memory state waits for mem_ready before fault.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  instruction opcode field, bits [15:12] of IR.
REQ-005 subop  input  4  IR bits [3:0]; selects lo/cl/co/st/nl when opcode=4'hE.
REQ-006 cond_true  input  1  ALU condition-flag match for br.
REQ-007 mem_ready  input  1  memory completes current read/write this cycle.
REQ-008 IorD, memRead, memWrite, MemtoReg, RegDst, RegWrite, IRWrite, PCWrite, PCWriteCond  output  1 each  datapath strobes.
REQ-009 ALUSrcA  output  1 (0=pc, 1=reg); ALUSrcB  output  2 (0=reg, 1=const 1, 2=imm); PCSource  output  2 (0=ALU, 1=branch target, 2=reg).
REQ-010 ALUOp  output  4  ALU operation code, encoded as opcode values.
REQ-011 halt  output  1  sticky halt; timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-012 States SHALL be FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT; outputs Moore-decoded from state, except IRWrite/PCWrite in FETCH, gated by mem_ready.
REQ-013 FETCH: IorD=0, memRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ad, PCSource=0; on mem_ready assert IRWrite and PCWrite for that cycle, go DECODE; else stay.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=2, ALUOp=ad (branch target precompute); next state: opcode 0x0-0x9 or li/si -> EXEC; lo/st -> MEM_ADDR; br -> BRANCH; jr -> JUMP; sy -> HALT; nl -> FETCH; 4'hE with subop 2 (co) -> EXEC; subop 1 (cl) -> EXEC; subop>4 -> HALT.
REQ-015 EXEC: ALUSrcA=1, ALUSrcB=2 for li/si else 0, ALUOp=opcode (co/cl: 4'hE); co -> FETCH with no writeback; others -> ALU_WB.
REQ-016 ALU_WB: RegDst=1, MemtoReg=0, RegWrite=1 for exactly one cycle -> FETCH.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ad; lo -> MEM_RD, st -> MEM_WR.
REQ-018 MEM_RD: IorD=1, memRead=1 until mem_ready, then MEM_WB; MEM_WB: MemtoReg=1, RegWrite=1 one cycle -> FETCH.
REQ-019 MEM_WR: IorD=1, memWrite=1 until mem_ready -> FETCH; memRead and memWrite SHALL never both be 1.
REQ-020 BRANCH: PCSource=1, PCWriteCond=1; PCWrite=cond_true sampled this cycle -> FETCH; JUMP: PCSource=2, PCWrite=1 -> FETCH.
REQ-021 Wait counter SHALL clear on entering FETCH, MEM_RD or MEM_WR, increment each cycle mem_ready=0 in them; reaching MEM_TIMEOUT -> HALT with timeout_err=1.
REQ-022 mem_ready in same cycle as timeout reach: completion wins, no fault.
REQ-023 HALT: all strobes 0, halt=1; remains until reset.
REQ-024 Strobes not listed for a state SHALL be 0; selects not listed SHALL be 0.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=FETCH, counter=0, halt=0, timeout_err=0, from any state including mid memory wait.
REQ-026 While reset is high all strobe outputs SHALL be 0.

Structure
REQ-027 Shared package mc_pkg SHALL hold opcode/subop constants, state encoding, ALUSrcB and PCSource codes.
REQ-028 Wait counter SHALL be sub-module mem_wait_timer (inputs clear, count; output expired).

Verification
REQ-029 Reset then opcode=0 (ad), mem_ready=1 -> FETCH,DECODE,EXEC,ALU_WB; RegWrite=1 only in 4th cycle; back to FETCH cycle 5.
REQ-030 lo with mem_ready delayed 3 cycles in MEM_RD -> memRead held 4 cycles, then MemtoReg=1, RegWrite=1 one cycle.
REQ-031 br with cond_true=0 -> PCWrite=0 in BRANCH; cond_true=1 -> PCWrite=1, PCSource=1.
REQ-032 st with mem_ready held 0, MEM_TIMEOUT=16 -> HALT after 16 wait cycles, timeout_err=1, memWrite=0 after.
REQ-033 sy -> halt=1 sticky over 20 cycles; reset pulse -> halt=0, FETCH next cycle.
REQ-034 reset asserted during MEM_RD wait -> FETCH next edge, all strobes 0 during reset.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared opcode/subop constants, FSM state encoding and datapath select codes
// for the multicycle control sequencer.
// Pure definitions: no latency, no flow control.
package mc_pkg;

    localparam logic [3:0] OP_AD  = 4'h0;
    localparam logic [3:0] OP_LI  = 4'hA;
    localparam logic [3:0] OP_SI  = 4'hB;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_JR  = 4'hD;
    localparam logic [3:0] OP_EXT = 4'hE;
    localparam logic [3:0] OP_SY  = 4'hF;

    // Subop field, meaningful only when opcode == OP_EXT
    localparam logic [3:0] SUB_LO = 4'd0;
    localparam logic [3:0] SUB_CL = 4'd1;
    localparam logic [3:0] SUB_CO = 4'd2;
    localparam logic [3:0] SUB_ST = 4'd3;
    localparam logic [3:0] SUB_NL = 4'd4;

    localparam logic [1:0] ALUB_REG = 2'd0;
    localparam logic [1:0] ALUB_ONE = 2'd1;
    localparam logic [1:0] ALUB_IMM = 2'd2;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_BRANCH = 2'd1;
    localparam logic [1:0] PCS_REG    = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } stateT;

    function automatic logic isImmOp(input logic [3:0] op);
        return (op == OP_LI) || (op == OP_SI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has spent waiting; expired marks the last allowed cycle.
// Latency: expired is combinational from the count register; clear wins over count.
// No flow control: count simply holds once expired.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] waitCnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            waitCnt <= '0;
        end else if (count && !expired) begin
            waitCnt <= waitCnt + W'(1);
        end
    end

    // Expired during the MEM_TIMEOUT-th waiting cycle, so that cycle is the last one
    assign expired = (waitCnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle CPU control FSM: Moore datapath strobes with mem_ready-gated fetch and memory timeout.
// Latency: one state per cycle; memory states stall on mem_ready for up to MEM_TIMEOUT cycles.
// Backpressure: mem_ready low holds FETCH/MEM_RD/MEM_WR; expiry forces a sticky HALT.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] subop,
    input  logic       cond_true,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       halt,
    output logic       timeout_err
);

    stateT state;
    stateT nextState;
    logic  waitState;
    logic  timerExpired;
    logic  timeoutHit;

    assign waitState  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeoutHit = waitState && !mem_ready && timerExpired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) waitTimer (
        .clk    (clk),
        .clear  (reset || (nextState != state)),
        .count  (waitState && !mem_ready),
        .expired(timerExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            timeout_err <= 1'b0;
        end else begin
            state <= nextState;
            if (timeoutHit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign halt = (state == S_HALT);

    always_comb begin
        nextState   = state;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUB_REG;
        PCSource    = PCS_ALU;
        ALUOp       = OP_AD;

        // Strobes stay quiet for the whole reset cycle, not just after the edge
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    ALUSrcB = ALUB_ONE;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        nextState = S_DECODE;
                    end else if (timerExpired) begin
                        nextState = S_HALT;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = ALUB_IMM;
                    if (opcode <= 4'h9 || isImmOp(opcode)) begin
                        nextState = S_EXEC;
                    end else if (opcode == OP_BR) begin
                        nextState = S_BRANCH;
                    end else if (opcode == OP_JR) begin
                        nextState = S_JUMP;
                    end else if (opcode == OP_EXT) begin
                        if (subop == SUB_LO || subop == SUB_ST) begin
                            nextState = S_MEM_ADDR;
                        end else if (subop == SUB_CL || subop == SUB_CO) begin
                            nextState = S_EXEC;
                        end else if (subop == SUB_NL) begin
                            nextState = S_FETCH;
                        end else begin
                            nextState = S_HALT;
                        end
                    end else begin
                        nextState = S_HALT;
                    end
                end
                S_EXEC: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = isImmOp(opcode) ? ALUB_IMM : ALUB_REG;
                    ALUOp     = opcode;
                    // Compare only sets flags, nothing to write back
                    nextState = (opcode == OP_EXT && subop == SUB_CO) ? S_FETCH : S_ALU_WB;
                end
                S_ALU_WB: begin
                    RegDst    = 1'b1;
                    RegWrite  = 1'b1;
                    nextState = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = ALUB_IMM;
                    nextState = (subop == SUB_ST) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                    if (mem_ready) begin
                        nextState = S_MEM_WB;
                    end else if (timerExpired) begin
                        nextState = S_HALT;
                    end
                end
                S_MEM_WB: begin
                    MemtoReg  = 1'b1;
                    RegWrite  = 1'b1;
                    nextState = S_FETCH;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    if (mem_ready) begin
                        nextState = S_FETCH;
                    end else if (timerExpired) begin
                        nextState = S_HALT;
                    end
                end
                S_BRANCH: begin
                    PCSource    = PCS_BRANCH;
                    PCWriteCond = 1'b1;
                    PCWrite     = cond_true;
                    nextState   = S_FETCH;
                end
                S_JUMP: begin
                    PCSource  = PCS_REG;
                    PCWrite   = 1'b1;
                    nextState = S_FETCH;
                end
                S_HALT: begin
                    nextState = S_HALT;
                end
                default: begin
                    nextState = S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: walks each instruction class and compares packed strobes per cycle.
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic [3:0] subop = 4'h0;
    logic       cond_true = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IorD, memRead, memWrite, MemtoReg, RegDst, RegWrite;
    logic       IRWrite, PCWrite, PCWriteCond, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic       halt, timeout_err;

    int checkCount = 0;
    int errorCount = 0;
    logic [1:0]  expFlags = 2'b00;
    logic [18:0] strobes;

    always #5 clk = ~clk;

    mc_sequencer #(
        .MEM_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .subop      (subop),
        .cond_true  (cond_true),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .halt       (halt),
        .timeout_err(timeout_err)
    );

    assign strobes = {IorD, memRead, memWrite, MemtoReg, RegDst, RegWrite, IRWrite,
                      PCWrite, PCWriteCond, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    function automatic logic [18:0] mk(input logic iord, mr, mw, m2r, rd, rw, irw, pcw, pcwc, asa,
                                       input logic [1:0] asb, pcs, input logic [3:0] op);
        return {iord, mr, mw, m2r, rd, rw, irw, pcw, pcwc, asa, asb, pcs, op};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive mem_ready, check current-state outputs, advance past the edge
    task automatic cyc(input string tag, input logic mr, input logic [18:0] exp);
        mem_ready = mr;
        #1;
        checkVal(tag, 32'(strobes), 32'(exp));
        checkVal({tag, ".flags"}, 32'({halt, timeout_err}), 32'(expFlags));
        @(posedge clk);
        #1;
    endtask

    logic [18:0] vZero, vFetchW, vFetchR, vDecode, vAluWb, vMemAddr, vMemRd, vMemWb, vMemWr;
    logic [18:0] vBr0, vBr1, vJump;

    task automatic fetchDecode(input string tag);
        cyc({tag, ".fetch"}, 1'b1, vFetchR);
        cyc({tag, ".decode"}, 1'b1, vDecode);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkVal({tag, ".inreset"}, 32'(strobes), 32'(vZero));
        @(posedge clk);
        #1;
        reset = 1'b0;
        expFlags = 2'b00;
    endtask

    initial begin
        vZero    = '0;
        vFetchW  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 4'h0);
        vFetchR  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 2'd1, 2'd0, 4'h0);
        vDecode  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'h0);
        vAluWb   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'h0);
        vMemAddr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 4'h0);
        vMemRd   = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'h0);
        vMemWb   = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'h0);
        vMemWr   = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'h0);
        vBr0     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 4'h0);
        vBr1     = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd1, 4'h0);
        vJump    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd2, 4'h0);

        // Reset: strobes held low even with mem_ready high, flags cleared
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkVal("reset.strobes", 32'(strobes), 32'(vZero));
        checkVal("reset.flags", 32'({halt, timeout_err}), 32'(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ad: FETCH, DECODE, EXEC, ALU_WB, FETCH
        opcode = 4'h0; subop = 4'h0;
        fetchDecode("ad");
        cyc("ad.exec", 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'h0));
        cyc("ad.wb", 1'b1, vAluWb);

        // Register op with a nonzero ALUOp
        opcode = 4'h7;
        fetchDecode("op7");
        cyc("op7.exec", 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'h7));
        cyc("op7.wb", 1'b1, vAluWb);

        // lo with mem_ready late by 3 cycles
        opcode = 4'hE; subop = 4'd0;
        fetchDecode("lo");
        cyc("lo.addr", 1'b1, vMemAddr);
        for (int i = 0; i < 3; i++) cyc("lo.rdwait", 1'b0, vMemRd);
        cyc("lo.rd", 1'b1, vMemRd);
        cyc("lo.wb", 1'b1, vMemWb);

        // li uses immediate operand
        opcode = 4'hA; subop = 4'd0;
        fetchDecode("li");
        cyc("li.exec", 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 4'hA));
        cyc("li.wb", 1'b1, vAluWb);

        // co: EXEC then straight back to FETCH
        opcode = 4'hE; subop = 4'd2;
        fetchDecode("co");
        cyc("co.exec", 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'hE));
        cyc("co.back", 1'b0, vFetchW);

        // cl: EXEC then writeback
        subop = 4'd1;
        fetchDecode("cl");
        cyc("cl.exec", 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'hE));
        cyc("cl.wb", 1'b1, vAluWb);

        // br not taken, then taken
        opcode = 4'hC; cond_true = 1'b0;
        fetchDecode("br0");
        cyc("br0.branch", 1'b1, vBr0);
        cond_true = 1'b1;
        fetchDecode("br1");
        cyc("br1.branch", 1'b1, vBr1);
        cond_true = 1'b0;

        // jr
        opcode = 4'hD;
        fetchDecode("jr");
        cyc("jr.jump", 1'b1, vJump);

        // nl: DECODE returns to FETCH
        opcode = 4'hE; subop = 4'd4;
        fetchDecode("nl");
        cyc("nl.back", 1'b0, vFetchW);

        // st: mem_ready arrives on the 16th wait cycle, completion wins
        subop = 4'd3;
        fetchDecode("stok");
        cyc("stok.addr", 1'b1, vMemAddr);
        for (int i = 0; i < 15; i++) cyc("stok.wait", 1'b0, vMemWr);
        cyc("stok.last", 1'b1, vMemWr);
        cyc("stok.back", 1'b0, vFetchW);

        // st: mem_ready never comes, timeout after 16 wait cycles
        fetchDecode("sto");
        cyc("sto.addr", 1'b1, vMemAddr);
        for (int i = 0; i < 16; i++) cyc("sto.wait", 1'b0, vMemWr);
        expFlags = 2'b11;
        cyc("sto.halt0", 1'b0, vZero);
        cyc("sto.halt1", 1'b1, vZero);
        doReset("sto");
        cyc("sto.refetch", 1'b0, vFetchW);

        // sy: sticky halt over 20 cycles, then reset releases it
        opcode = 4'hF; subop = 4'd0;
        fetchDecode("sy");
        expFlags = 2'b10;
        for (int i = 0; i < 20; i++) cyc("sy.halt", 1'(i % 2), vZero);
        doReset("sy");
        cyc("sy.refetch", 1'b0, vFetchW);

        // Undefined subop halts without a timeout
        opcode = 4'hE; subop = 4'd5;
        fetchDecode("sub5");
        expFlags = 2'b10;
        cyc("sub5.halt", 1'b1, vZero);
        doReset("sub5");

        // Reset during MEM_RD wait; counter must restart so 15 fetch waits are tolerated
        subop = 4'd0;
        fetchDecode("rrd");
        cyc("rrd.addr", 1'b1, vMemAddr);
        for (int i = 0; i < 2; i++) cyc("rrd.rdwait", 1'b0, vMemRd);
        doReset("rrd");
        for (int i = 0; i < 15; i++) cyc("rrd.fwait", 1'b0, vFetchW);
        fetchDecode("rrd2");
        cyc("rrd2.addr", 1'b1, vMemAddr);
        cyc("rrd2.rd", 1'b1, vMemRd);
        cyc("rrd2.wb", 1'b1, vMemWb);

        // Fetch timeout
        for (int i = 0; i < 16; i++) cyc("fto.wait", 1'b0, vFetchW);
        expFlags = 2'b11;
        cyc("fto.halt", 1'b1, vZero);
        doReset("fto");
        cyc("fto.refetch", 1'b1, vFetchR);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
